// File: rtl/hazard_fwd_ctrl_if.sv
// Signal bundle between the RV32I pipeline and its forwarding/hazard controller.
// The master drives ID decode fields, branch and hold; the slave returns selects, enables and counters.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output hold, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    input  forward_a, forward_b, pc_write, if_id_write, if_id_flush,
           id_ex_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    output forward_a, forward_b, pc_write, if_id_write, if_id_flush,
           id_ex_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller for a 5-stage RV32I pipeline: registered EX operand
// selects from a shadow copy of EX/MEM/WB destinations, load-use stalls, branch flushes.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              wb_rw_q, wb_rw_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic lu;
  logic bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // The instruction now in EX lands in MEM next cycle (select 10); the one in MEM lands in WB (01).
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              uses,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_rw,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_rw
  );
    if (!uses || rs == '0)       return 2'b00;
    else if (e_rw && e_rd == rs) return 2'b10;
    else if (m_rw && m_rd == rs) return 2'b01;
    else                         return 2'b00;
  endfunction

  // The WB shadow has no consumer: WB-to-ID hazards are covered by the write-first register file.
  logic unused_wb;
  assign unused_wb = ^{wb_rd_q, wb_rw_q};

  always_comb begin
    lu = bus.id_valid && ex_mr_q && (ex_rd_q != '0) &&
         ((bus.id_uses_rs1 && bus.id_rs1 == ex_rd_q) ||
          (bus.id_uses_rs2 && bus.id_rs2 == ex_rd_q));
    bubble = !bus.id_valid || lu || bus.ex_branch_taken;

    bus.pc_write    = !bus.hold && (bus.ex_branch_taken || !lu);
    bus.if_id_write = !bus.hold && (bus.ex_branch_taken || !lu);
    bus.if_id_flush = !bus.hold && bus.ex_branch_taken;
    bus.id_ex_flush = !bus.hold && (bus.ex_branch_taken || lu);

    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!bus.hold) begin
      wb_rd_d  = mem_rd_q;
      wb_rw_d  = mem_rw_q;
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      if (bubble) begin
        ex_rd_d = '0;
        ex_rw_d = 1'b0;
        ex_mr_d = 1'b0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        ex_rd_d = bus.id_rd;
        ex_rw_d = bus.id_reg_write;
        ex_mr_d = bus.id_mem_read;
        fwd_a_d = fwd_sel(bus.id_rs1, bus.id_uses_rs1, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
        fwd_b_d = fwd_sel(bus.id_rs2, bus.id_uses_rs2, ex_rd_q, ex_rw_q, mem_rd_q, mem_rw_q);
      end
      if (bus.ex_branch_taken)
        flush_cnt_d = sat_inc(flush_cnt_q);
      else if (lu)
        stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.forward_a = fwd_a_q;
  assign bus.forward_b = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed pipeline scenarios plus random instruction streams,
// checked every cycle against an instruction-slot model of the EX/MEM/WB pipeline.
module tb_hazard_fwd_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
  hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: one record per in-flight instruction slot.
  typedef struct { bit rw; bit mr; int rd; } slot_t;
  slot_t m_ex, m_mem, m_wb;
  int m_fa, m_fb, m_stall, m_flush;

  function automatic int producer_src(int r, bit uses);
    if (!uses || r == 0) return 0;
    if (m_ex.rw && m_ex.rd == r) return 2;   // youngest producer wins
    if (m_mem.rw && m_mem.rd == r) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0};
    m_fa = 0; m_fb = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input bit v, input int rd, input bit rw, input bit mr,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit br, input bit hd);
    bus.id_valid = v;        bus.id_rd = REG_AW'(rd);
    bus.id_reg_write = rw;   bus.id_mem_read = mr;
    bus.id_rs1 = REG_AW'(rs1); bus.id_uses_rs1 = u1;
    bus.id_rs2 = REG_AW'(rs2); bus.id_uses_rs2 = u2;
    bus.ex_branch_taken = br; bus.hold = hd;
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit lu, br, hd, stall;
    int e_pc, e_ifw, e_iff, e_idf;
    @(negedge clk);
    br = bus.ex_branch_taken; hd = bus.hold;
    lu = bus.id_valid && m_ex.mr && m_ex.rd != 0 &&
         ((bus.id_uses_rs1 && int'(bus.id_rs1) == m_ex.rd) ||
          (bus.id_uses_rs2 && int'(bus.id_rs2) == m_ex.rd));
    stall = lu && !br;
    e_pc  = (!hd && !stall) ? 1 : 0;
    e_ifw = e_pc;
    e_iff = (!hd && br) ? 1 : 0;
    e_idf = (!hd && (br || lu)) ? 1 : 0;
    check("pc_write",    bus.pc_write,    e_pc);
    check("if_id_write", bus.if_id_write, e_ifw);
    check("if_id_flush", bus.if_id_flush, e_iff);
    check("id_ex_flush", bus.id_ex_flush, e_idf);
    check("forward_a",   bus.forward_a,   m_fa);
    check("forward_b",   bus.forward_b,   m_fb);
    check("stall_cnt",   bus.stall_cnt,   m_stall);
    check("flush_cnt",   bus.flush_cnt,   m_flush);
    if (!hd) begin
      if (!bus.id_valid || lu || br) begin
        m_fa = 0; m_fb = 0;
      end else begin
        m_fa = producer_src(int'(bus.id_rs1), bus.id_uses_rs1);
        m_fb = producer_src(int'(bus.id_rs2), bus.id_uses_rs2);
      end
      m_wb  = m_mem;
      m_mem = '{m_ex.rw, 0, m_ex.rd};
      if (!bus.id_valid || lu || br) m_ex = '{0, 0, 0};
      else m_ex = '{bus.id_reg_write, bus.id_mem_read, int'(bus.id_rd)};
      if (br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      else if (lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int rd, input bit rw, input bit mr, input int rs1, input bit u1,
                     input int rs2, input bit u2, input bit br = 0, input bit hd = 0);
    drive(1, rd, rw, mr, rs1, u1, rs2, u2, br, hd);
    cycle();
  endtask

  task automatic nop_slot();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  int st0, fl0;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_fwd_a", bus.forward_a, 0);
    check("rst_fwd_b", bus.forward_b, 0);
    check("rst_stall", bus.stall_cnt, 0);
    check("rst_flush", bus.flush_cnt, 0);
    check("rst_pc_write", bus.pc_write, 1);
    check("rst_ifid_write", bus.if_id_write, 1);
    check("rst_flushes", {bus.if_id_flush, bus.id_ex_flush}, 0);
    rst = 1'b0;

    // add x5 ; sub x6,x5,x3 -> MEM forward on A
    ins(5, 1, 0, 1, 1, 2, 1);
    ins(6, 1, 0, 5, 1, 3, 1);
    check("plan1_fa", bus.forward_a, 2);
    check("plan1_fb", bus.forward_b, 0);
    nop_slot(); nop_slot();

    // add x5 ; nop ; or reading x5 as rs2 -> WB forward
    ins(5, 1, 0, 1, 1, 2, 1);
    ins(0, 1, 0, 0, 1, 0, 1);
    ins(8, 1, 0, 1, 1, 5, 1);
    check("plan2_fb_wb", bus.forward_b, 1);
    // add x5 ; add x5 ; or reading x5 -> MEM wins
    ins(5, 1, 0, 1, 1, 2, 1);
    ins(5, 1, 0, 3, 1, 4, 1);
    ins(8, 1, 0, 1, 1, 5, 1);
    check("plan2_fb_mem", bus.forward_b, 2);
    nop_slot(); nop_slot();

    // lw x7 ; add x8,x7 -> one stall, then WB forward
    st0 = m_stall;
    ins(7, 1, 1, 1, 1, 0, 0);
    ins(8, 1, 0, 7, 1, 2, 1);
    check("plan3_stall_cnt", bus.stall_cnt, st0 + 1);
    ins(8, 1, 0, 7, 1, 2, 1);
    check("plan3_fa", bus.forward_a, 1);
    nop_slot(); nop_slot();

    // lw x7 ; dependent add with branch taken -> flush only
    st0 = m_stall; fl0 = m_flush;
    ins(7, 1, 1, 1, 1, 0, 0);
    ins(8, 1, 0, 7, 1, 2, 1, 1);
    check("plan4_stall_same", bus.stall_cnt, st0);
    check("plan4_flush_inc", bus.flush_cnt, fl0 + 1);
    nop_slot(); nop_slot();

    // x0 is never forwarded, load to x0 never stalls
    ins(0, 1, 0, 1, 1, 2, 1);
    ins(9, 1, 0, 0, 1, 0, 1);
    check("plan5_fa_x0", bus.forward_a, 0);
    st0 = m_stall;
    ins(0, 1, 1, 1, 1, 0, 0);
    ins(9, 1, 0, 0, 1, 0, 1);
    check("plan5_no_stall", bus.stall_cnt, st0);
    nop_slot(); nop_slot();

    // hold over a load-use for 3 cycles, then exactly one stall
    st0 = m_stall;
    ins(7, 1, 1, 1, 1, 0, 0);
    repeat (3) ins(8, 1, 0, 7, 1, 0, 0, 0, 1);
    check("plan6_hold_cnt", bus.stall_cnt, st0);
    ins(8, 1, 0, 7, 1, 0, 0);
    ins(8, 1, 0, 7, 1, 0, 0);
    check("plan6_one_stall", bus.stall_cnt, st0 + 1);
    nop_slot(); nop_slot();

    // reset asserted in the middle of a stall cycle
    ins(7, 1, 1, 1, 1, 0, 0);
    drive(1, 8, 1, 0, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_stall_pc_write_pre", bus.pc_write, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_pc_write", bus.pc_write, 1);
    check("rst_mid_idex_flush", bus.id_ex_flush, 0);
    check("rst_mid_fwd", {bus.forward_a, bus.forward_b}, 0);
    check("rst_mid_cnts", {bus.stall_cnt, bus.flush_cnt}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ins(8, 1, 0, 7, 1, 0, 0);

    // random streams over a small register set, long enough to saturate both counters
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 85, $urandom_range(3), $urandom_range(1), $urandom_range(2) == 0,
            $urandom_range(3), $urandom_range(1), $urandom_range(3), $urandom_range(1),
            $urandom_range(99) < 8, $urandom_range(99) < 10);
      cycle();
    end
    check("sat_stall", bus.stall_cnt, CMAX);
    check("sat_flush", bus.flush_cnt, CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage RV32I pipeline.
- Drives the 2-bit selects of the two EX-stage 3:1 operand muxes: 00 = register-file value, 01 = WB result, 10 = MEM result.
- Keeps its own shadow copy of destination-register info for EX/MEM/WB, so it needs only ID-stage decode fields plus branch and hold inputs.
- Generates load-use stalls, bubbles and branch flushes, and counts stall and flush events.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the event counters (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- hold  in  1  global freeze (memory busy); all internal state holds.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  ID destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- forward_a  out  2  select for EX operand-A mux (registered).
- forward_b  out  2  select for EX operand-B mux (registered).
- pc_write  out  1  PC enable (combinational).
- if_id_write  out  1  IF/ID register enable (combinational).
- if_id_flush  out  1  zero the IF/ID register (combinational).
- id_ex_flush  out  1  insert a bubble into ID/EX (combinational).
- stall_cnt  out  CNT_W  load-use stall cycles since reset.
- flush_cnt  out  CNT_W  taken-branch flushes since reset.

Behaviour:
- Shadow registers: ex_{rd,rw,mr}, mem_{rd,rw}, wb_{rd,rw}.
- Every non-hold cycle they advance ID->EX->MEM->WB; EX is loaded from ID or with a bubble (rw=0, mr=0, rd=0).
- id_valid=0 loads EX as a bubble.
- Reset (async, takes effect immediately):
  - all shadow regs 0;
  - forward_a/b = 00;
  - both counters 0;
  - pc_write=1, if_id_write=1, both flushes 0 (with hold=0 and no branch).
- Load-use hazard, lu:
  - condition: id_valid & ex_mr & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd));
  - response: pc_write=0, if_id_write=0, id_ex_flush=1, and a bubble is loaded into EX;
  - exactly one stall cycle, because next cycle the load sits in MEM and lu is false.
- Branch flush:
  - ex_branch_taken=1 gives if_id_flush=1 and id_ex_flush=1, and a bubble is loaded into EX;
  - pc_write=1, if_id_write=1.
- Priority (highest first):
  - hold: pc_write=0, if_id_write=0, no flushes, state frozen, counters frozen;
  - branch flush: overrides lu; no stall is counted;
  - lu;
  - normal advance.
- Forward selects:
  - registered, computed when ID advances into EX, and valid for the whole EX cycle of that instruction;
  - operand A: 10 if ex_rw & ex_rd!=0 & ex_rd==id_rs1 (producer moves to MEM);
  - else 01 if mem_rw & mem_rd!=0 & mem_rd==id_rs1 (producer moves to WB);
  - else 00. Operand B is the same with id_rs2.
  - MEM beats WB when both match; x0 is never forwarded; id_uses_rsX=0 forces 00.
  - On a bubble load (lu, flush, id_valid=0) the selects become 00.
  - During hold the selects hold their value.
- WB-to-ID same-cycle write is resolved by the register file's write-first behaviour; no select is generated for it.
- Counters:
  - stall_cnt increments on each cycle with lu & !hold & !ex_branch_taken;
  - flush_cnt increments on each cycle with ex_branch_taken & !hold;
  - both saturate at all-ones.
- Reset mid-stall: state clears, and the next cycle is a normal advance with no residual bubble.

Test Plan:
- add x5 in ID, then next cycle `sub` reading x5 as rs1 -> on sub's EX cycle forward_a=10, forward_b=00; no stall.
- add x5, nop, `or` reading x5 as rs2 -> forward_b=01 on or's EX cycle; with x5 also produced in the intervening slot, forward_b=10 (MEM priority).
- lw x7, then add reading x7 as rs1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0->1; add's EX cycle has forward_a=01.
- lw x7 followed by a dependent add, with ex_branch_taken=1 in the same cycle -> flushes only, pc_write=1, stall_cnt unchanged, flush_cnt +1.
- Instruction writing x0, then a reader of x0 -> forward_a=00; a load to x0 followed by a reader of x0 -> no stall.
- hold=1 for 3 cycles during a load-use case -> outputs and counters frozen, no flush; after release, exactly one stall cycle. Assert rst during a stall -> forward=00, pc_write=1, counters 0 immediately.
